cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle fetch/decode/execute/writeback controller for the master CPU datapath (RAM, register bank, master ALU).
- Drives the RAM fetch address from a program counter and latches the instruction word.
- Splits the instruction into register-bank, ALU and condition fields, evaluates the condition against stored NZCV flags, and sequences LDR/STR accesses and register writeback.

Parameters:
- DATA_W, 32, instruction/data word width
- ADDR_W, 16, RAM address width
- PC_W, 8, program counter width; zero-extended onto Mem_Address

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  one-cycle pulse; begins execution at Start_Addr (from IDLE or HALT only)
- Start_Addr  in  PC_W  initial PC
- Mem_Enable  out  1  RAM access request
- Mem_RW  out  1  1 = read, 0 = write
- Mem_Address  out  ADDR_W  RAM address
- Mem_Wdata  out  DATA_W  store data
- Mem_Rdata  in  DATA_W  RAM read data, valid when Mem_Ready = 1
- Mem_Ready  in  1  access complete this cycle
- Instruction  out  DATA_W  latched instruction register (IR)
- PC  out  PC_W  program counter
- Reg_Src1, Reg_Src2, Reg_Dest  out  4 each  IR[14:11], IR[18:15], IR[22:19]
- Reg_Rdata1, Reg_Rdata2  in  DATA_W  register bank read ports (combinational)
- Alu_Result  in  DATA_W  ALU result (combinational from IR and register data)
- Alu_Flags  in  4  ALU NZCV
- Reg_We  out  1  register write strobe
- Reg_Wdata  out  DATA_W  register write data
- Flags  out  4  architectural NZCV (bit3 = N … bit0 = V)
- Busy  out  1  high in every state except IDLE and HALT
- Halted  out  1  high in HALT

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-access):
  - state = IDLE.
  - PC, IR, Flags, Reg_Wdata and the internal result register = 0.
  - Mem_Enable = 0, Mem_RW = 1, Mem_Address = 0, Mem_Wdata = 0, Reg_We = 0, Busy = 0, Halted = 0.
- IR field decode:
  - Cond = IR[31:28], OpCode = IR[27:24], S = IR[23].
- States:
  - IDLE: Start = 1 -> PC <= Start_Addr, go to FETCH.
  - FETCH:
    - Drive Mem_Enable = 1, Mem_RW = 1, Mem_Address = {0, PC}.
    - Hold these outputs stable until Mem_Ready = 1; Mem_Ready in the first cycle is accepted (zero wait).
    - On Mem_Ready: IR <= Mem_Rdata, PC <= PC + 1 (wraps 255 -> 0), go to DECODE.
  - DECODE (1 cycle, Mem_Enable = 0):
    - Condition fails -> FETCH; the instruction has no effect, even if it is HALT.
    - Else OpCode = HALT -> HALT.
    - Else OpCode = LDR or STR -> MEM.
    - Else -> EXECUTE.
  - EXECUTE (1 cycle):
    - result <= Alu_Result.
    - If S = 1, Flags <= Alu_Flags.
    - Go to WRITEBACK.
  - MEM:
    - Mem_Enable = 1, Mem_Address = Reg_Rdata1[ADDR_W-1:0].
    - LDR: Mem_RW = 1. On Mem_Ready, result <= Mem_Rdata, go to WRITEBACK.
    - STR: Mem_RW = 0, Mem_Wdata = Reg_Rdata2. On Mem_Ready, go to FETCH.
  - WRITEBACK (1 cycle): Reg_We = 1, Reg_Wdata = result, go to FETCH.
  - HALT: Start = 1 -> PC <= Start_Addr, go to FETCH.
- Cycle counts with zero-wait memory:
  - ALU instruction: 4 cycles.
  - LDR: 4 cycles.
  - STR: 3 cycles.
  - Failed condition: 2 cycles.
- Condition codes (ARM encoding): 0 EQ, 1 NE, 2 CS, 3 CC, 4 MI, 5 PL, 6 VS, 7 VC, 8 HI, 9 LS, A GE, B LT, C GT, D LE, E AL; F = never.
- Boundary rules:
  - Start while Busy is ignored.
  - Mem_Ready while Mem_Enable = 0 is ignored.
  - Flags change only in EXECUTE with S = 1; LDR/STR never change Flags.
  - Reg_We is a single-cycle pulse and is never asserted outside WRITEBACK.
  - Reset asserted during a wait state drops Mem_Enable immediately; no partial writeback occurs.

Decomposition:
- Package cpu_pkg:
  - State enum: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
  - Opcode constants: OP_LDR = 4'hA, OP_STR = 4'hB, OP_HALT = 4'hF.
  - Condition-code constants and NZCV bit indices.
- One combinational sub-module, cond_check: inputs Cond and Flags, output pass.

Test Plan:
- Reset/start: Reset low mid-FETCH -> Mem_Enable = 0 and PC = 0 at once. Release, pulse Start with Start_Addr = 8'h10 -> next cycle Mem_Address = 16'h0010, Mem_RW = 1.
- ALU op, zero-wait RAM: instruction AL, S = 1, Alu_Result = 20, Alu_Flags = 4'b0000 -> Reg_We pulses in cycle 4 with Reg_Wdata = 20, Flags = 0, PC incremented by 1.
- Conditional skip: Flags Z = 0, instruction Cond = EQ -> no Reg_We, next FETCH after 2 cycles. Same instruction with Cond = NE -> executes.
- LDR with 2 wait states: Reg_Rdata1 = 32'h0005, RAM returns 32'hDEADBEEF -> Mem_Address = 5 held for 3 cycles, then Reg_We with Reg_Wdata = 32'hDEADBEEF.
- STR: Reg_Rdata1 = 7, Reg_Rdata2 = 99 -> Mem_RW = 0, Mem_Address = 7, Mem_Wdata = 99, no Reg_We, Flags unchanged.
- HALT and wrap: program ends in HALT at PC = 8'hFF -> PC = 8'h00, Halted = 1, Start ignored while Busy; Start in HALT restarts at Start_Addr.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the master CPU sequencer: FSM states,
// opcode values, ARM-style condition codes and NZCV bit positions.
package cpu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXECUTE,
      MEM,
      WRITEBACK,
      HALT
   } state_t;

   localparam logic [3:0] OP_LDR  = 4'hA;
   localparam logic [3:0] OP_STR  = 4'hB;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of an ARM-style condition field against the
// stored NZCV flags.
module cond_check
   import cpu_pkg::*;
(
   input  logic [3:0] i_cond,
   input  logic [3:0] i_flags,
   output logic       o_pass
);

   logic w_n, w_z, w_c, w_v;

   assign w_n = i_flags[FLAG_N];
   assign w_z = i_flags[FLAG_Z];
   assign w_c = i_flags[FLAG_C];
   assign w_v = i_flags[FLAG_V];

   always_comb begin
      o_pass = 1'b0;
      case (i_cond)
         COND_EQ: o_pass = w_z;
         COND_NE: o_pass = ~w_z;
         COND_CS: o_pass = w_c;
         COND_CC: o_pass = ~w_c;
         COND_MI: o_pass = w_n;
         COND_PL: o_pass = ~w_n;
         COND_VS: o_pass = w_v;
         COND_VC: o_pass = ~w_v;
         COND_HI: o_pass = w_c & ~w_z;
         COND_LS: o_pass = ~w_c | w_z;
         COND_GE: o_pass = (w_n == w_v);
         COND_LT: o_pass = (w_n != w_v);
         COND_GT: o_pass = ~w_z & (w_n == w_v);
         COND_LE: o_pass = w_z | (w_n != w_v);
         COND_AL: o_pass = 1'b1;
         default: o_pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller driving RAM, register
// bank and ALU of the master CPU datapath.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16,
   parameter int PC_W   = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic [PC_W-1:0]   Start_Addr,
   output logic              Mem_Enable,
   output logic              Mem_RW,
   output logic [ADDR_W-1:0] Mem_Address,
   output logic [DATA_W-1:0] Mem_Wdata,
   input  logic [DATA_W-1:0] Mem_Rdata,
   input  logic              Mem_Ready,
   output logic [DATA_W-1:0] Instruction,
   output logic [PC_W-1:0]   PC,
   output logic [3:0]        Reg_Src1,
   output logic [3:0]        Reg_Src2,
   output logic [3:0]        Reg_Dest,
   input  logic [DATA_W-1:0] Reg_Rdata1,
   input  logic [DATA_W-1:0] Reg_Rdata2,
   input  logic [DATA_W-1:0] Alu_Result,
   input  logic [3:0]        Alu_Flags,
   output logic              Reg_We,
   output logic [DATA_W-1:0] Reg_Wdata,
   output logic [3:0]        Flags,
   output logic              Busy,
   output logic              Halted
);

   state_t            r_state, w_state_nxt;
   logic [PC_W-1:0]   r_pc;
   logic [DATA_W-1:0] r_ir;
   logic [DATA_W-1:0] r_result;
   logic [3:0]        r_flags;

   logic [3:0]        w_cond, w_opcode;
   logic              w_s, w_cond_pass, w_is_str;
   logic              w_unused;

   assign w_cond   = r_ir[31:28];
   assign w_opcode = r_ir[27:24];
   assign w_s      = r_ir[23];
   assign w_is_str = (w_opcode == OP_STR);
   // Only the low ADDR_W bits of the base register form a RAM address.
   assign w_unused = ^Reg_Rdata1[DATA_W-1:ADDR_W];

   cond_check u_cond_check (
      .i_cond  (w_cond),
      .i_flags (r_flags),
      .o_pass  (w_cond_pass)
   );

   assign Instruction = r_ir;
   assign PC          = r_pc;
   assign Flags       = r_flags;
   assign Reg_Wdata   = r_result;
   assign Reg_Src1    = r_ir[14:11];
   assign Reg_Src2    = r_ir[18:15];
   assign Reg_Dest    = r_ir[22:19];
   assign Busy        = (r_state != IDLE) && (r_state != HALT);
   assign Halted      = (r_state == HALT);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state  <= IDLE;
         r_pc     <= '0;
         r_ir     <= '0;
         r_result <= '0;
         r_flags  <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            IDLE, HALT: begin
               if (Start) r_pc <= Start_Addr;
            end
            FETCH: begin
               if (Mem_Ready) begin
                  r_ir <= Mem_Rdata;
                  r_pc <= r_pc + PC_W'(1);
               end
            end
            EXECUTE: begin
               r_result <= Alu_Result;
               if (w_s) r_flags <= Alu_Flags;
            end
            MEM: begin
               if (Mem_Ready && !w_is_str) r_result <= Mem_Rdata;
            end
            default: ;
         endcase
      end
   end

   // Memory strobes are purely state-decoded so reset drops them immediately.
   always_comb begin
      w_state_nxt = r_state;
      Mem_Enable  = 1'b0;
      Mem_RW      = 1'b1;
      Mem_Address = '0;
      Mem_Wdata   = '0;
      Reg_We      = 1'b0;
      case (r_state)
         IDLE, HALT: begin
            if (Start) w_state_nxt = FETCH;
         end
         FETCH: begin
            Mem_Enable  = 1'b1;
            Mem_Address = ADDR_W'(r_pc);
            if (Mem_Ready) w_state_nxt = DECODE;
         end
         DECODE: begin
            if (!w_cond_pass)
               w_state_nxt = FETCH;
            else if (w_opcode == OP_HALT)
               w_state_nxt = HALT;
            else if (w_opcode == OP_LDR || w_is_str)
               w_state_nxt = MEM;
            else
               w_state_nxt = EXECUTE;
         end
         EXECUTE: w_state_nxt = WRITEBACK;
         MEM: begin
            Mem_Enable  = 1'b1;
            Mem_Address = Reg_Rdata1[ADDR_W-1:0];
            if (w_is_str) begin
               Mem_RW    = 1'b0;
               Mem_Wdata = Reg_Rdata2;
            end
            if (Mem_Ready) w_state_nxt = w_is_str ? FETCH : WRITEBACK;
         end
         WRITEBACK: begin
            Reg_We      = 1'b1;
            w_state_nxt = FETCH;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed-vector bench for cpu_sequencer: drives RAM/regbank/ALU inputs cycle
// by cycle and compares the sequencer outputs with hand-computed values.
module tb_cpu_sequencer;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0;
   logic [7:0]  Start_Addr = '0;
   logic        Mem_Enable, Mem_RW;
   logic [15:0] Mem_Address;
   logic [31:0] Mem_Wdata;
   logic [31:0] Mem_Rdata = '0;
   logic        Mem_Ready = 1'b0;
   logic [31:0] Instruction;
   logic [7:0]  PC;
   logic [3:0]  Reg_Src1, Reg_Src2, Reg_Dest;
   logic [31:0] Reg_Rdata1 = '0;
   logic [31:0] Reg_Rdata2 = '0;
   logic [31:0] Alu_Result = '0;
   logic [3:0]  Alu_Flags = '0;
   logic        Reg_We;
   logic [31:0] Reg_Wdata;
   logic [3:0]  Flags;
   logic        Busy, Halted;

   int checks = 0;
   int errors = 0;

   cpu_sequencer #(.DATA_W(32), .ADDR_W(16), .PC_W(8)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Start_Addr(Start_Addr),
      .Mem_Enable(Mem_Enable), .Mem_RW(Mem_RW), .Mem_Address(Mem_Address),
      .Mem_Wdata(Mem_Wdata), .Mem_Rdata(Mem_Rdata), .Mem_Ready(Mem_Ready),
      .Instruction(Instruction), .PC(PC), .Reg_Src1(Reg_Src1),
      .Reg_Src2(Reg_Src2), .Reg_Dest(Reg_Dest), .Reg_Rdata1(Reg_Rdata1),
      .Reg_Rdata2(Reg_Rdata2), .Alu_Result(Alu_Result), .Alu_Flags(Alu_Flags),
      .Reg_We(Reg_We), .Reg_Wdata(Reg_Wdata), .Flags(Flags), .Busy(Busy),
      .Halted(Halted)
   );

   always #5 Clk = ~Clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic start_at(input logic [7:0] a);
      Start_Addr = a;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      #1 Reset = 1'b0;
      tick(); tick();
      checks++; if (Mem_Enable !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %b exp 0", Mem_Enable); end
      checks++; if (Mem_RW !== 1'b1) begin errors++; $display("FAIL rst_mem_rw: got %b exp 1", Mem_RW); end
      checks++; if ({Busy, Halted, Reg_We} !== 3'b000) begin errors++; $display("FAIL rst_status: got %b exp 000", {Busy, Halted, Reg_We}); end
      checks++; if ({PC, Flags, Mem_Address} !== 28'h0) begin errors++; $display("FAIL rst_regs: got %h exp 0", {PC, Flags, Mem_Address}); end
      Reset = 1'b1;
      Mem_Ready = 1'b1;
      tick(); tick();
      checks++; if ({Busy, Mem_Enable} !== 2'b00) begin errors++; $display("FAIL idle_ready_ignored: got %b exp 00", {Busy, Mem_Enable}); end
      Mem_Ready = 1'b0;
      start_at(8'h10);
      checks++; if (Mem_Address !== 16'h0010) begin errors++; $display("FAIL start_addr: got %h exp 0010", Mem_Address); end
      checks++; if ({Mem_Enable, Mem_RW, Busy} !== 3'b111) begin errors++; $display("FAIL start_fetch: got %b exp 111", {Mem_Enable, Mem_RW, Busy}); end
      tick();
      Reset = 1'b0;
      #1;
      checks++; if ({Mem_Enable, PC} !== 9'h000) begin errors++; $display("FAIL rst_mid_fetch: got %h exp 000", {Mem_Enable, PC}); end
      tick();
      Reset = 1'b1;
      tick();
   endtask

   task automatic test_alu();
      start_at(8'h10);
      // S=0: result 7, flags must not load
      Mem_Rdata = 32'hE1190800; Mem_Ready = 1'b1;
      tick();
      checks++; if (Instruction !== 32'hE1190800) begin errors++; $display("FAIL alu_ir: got %h exp E1190800", Instruction); end
      checks++; if ({Reg_Src1, Reg_Src2, Reg_Dest} !== 12'h123) begin errors++; $display("FAIL alu_fields: got %h exp 123", {Reg_Src1, Reg_Src2, Reg_Dest}); end
      checks++; if ({PC, Mem_Enable} !== 9'h022) begin errors++; $display("FAIL alu_decode_pc: got %h exp 022", {PC, Mem_Enable}); end
      Alu_Result = 32'd7; Alu_Flags = 4'b1111;
      tick();
      tick();
      checks++; if ({Reg_We, Reg_Wdata, Flags} !== {1'b1, 32'd7, 4'b0000}) begin errors++; $display("FAIL alu_nos_wb: got %b/%h/%b exp 1/7/0000", Reg_We, Reg_Wdata, Flags); end
      Mem_Rdata = 32'hE1990800;
      tick();
      checks++; if ({Reg_We, Mem_Enable, Mem_Address} !== {2'b01, 16'h0011}) begin errors++; $display("FAIL alu_next_fetch: got %b/%b/%h exp 0/1/0011", Reg_We, Mem_Enable, Mem_Address); end
      // S=1: result 20, flags load N,V
      tick();
      Alu_Result = 32'd20; Alu_Flags = 4'b1001;
      tick();
      checks++; if (Reg_We !== 1'b0) begin errors++; $display("FAIL alu_exec_we: got %b exp 0", Reg_We); end
      tick();
      checks++; if ({Reg_We, Reg_Wdata, Flags} !== {1'b1, 32'd20, 4'b1001}) begin errors++; $display("FAIL alu_s_wb: got %b/%h/%b exp 1/14/1001", Reg_We, Reg_Wdata, Flags); end
      tick();
      checks++; if ({Reg_We, PC} !== {1'b0, 8'h12}) begin errors++; $display("FAIL alu_we_pulse: got %b/%h exp 0/12", Reg_We, PC); end
   endtask

   task automatic test_cond();
      Mem_Rdata = 32'h01990800;
      tick();
      checks++; if (Reg_We !== 1'b0) begin errors++; $display("FAIL eq_skip_decode: got %b exp 0", Reg_We); end
      Mem_Rdata = 32'h0F000000;
      tick();
      checks++; if ({Reg_We, Mem_Enable, Mem_Address} !== {2'b01, 16'h0013}) begin errors++; $display("FAIL eq_skip_2cyc: got %b/%b/%h exp 0/1/0013", Reg_We, Mem_Enable, Mem_Address); end
      tick(); tick();
      checks++; if ({Halted, Mem_Enable, Mem_Address} !== {2'b01, 16'h0014}) begin errors++; $display("FAIL halt_skip: got %b/%b/%h exp 0/1/0014", Halted, Mem_Enable, Mem_Address); end
      Mem_Rdata = 32'h11190800;
      tick();
      Alu_Result = 32'h55;
      tick(); tick();
      checks++; if ({Reg_We, Reg_Wdata, Flags} !== {1'b1, 32'h55, 4'b1001}) begin errors++; $display("FAIL ne_exec: got %b/%h/%b exp 1/55/1001", Reg_We, Reg_Wdata, Flags); end
      tick();
   endtask

   task automatic test_ldr();
      Mem_Rdata = 32'hEA800000;
      tick();
      Reg_Rdata1 = 32'hABCD0005; Mem_Ready = 1'b0; Alu_Flags = 4'b0110;
      tick();
      checks++; if ({Mem_Enable, Mem_RW, Mem_Address} !== {2'b11, 16'h0005}) begin errors++; $display("FAIL ldr_wait1: got %b/%b/%h exp 1/1/0005", Mem_Enable, Mem_RW, Mem_Address); end
      tick();
      checks++; if ({Mem_Enable, Mem_Address, Reg_We} !== {1'b1, 16'h0005, 1'b0}) begin errors++; $display("FAIL ldr_wait2: got %b/%h/%b exp 1/0005/0", Mem_Enable, Mem_Address, Reg_We); end
      tick();
      Mem_Ready = 1'b1; Mem_Rdata = 32'hDEADBEEF;
      #1;
      checks++; if ({Mem_Enable, Mem_Address} !== {1'b1, 16'h0005}) begin errors++; $display("FAIL ldr_wait3: got %b/%h exp 1/0005", Mem_Enable, Mem_Address); end
      tick();
      checks++; if ({Reg_We, Reg_Wdata, Flags} !== {1'b1, 32'hDEADBEEF, 4'b1001}) begin errors++; $display("FAIL ldr_wb: got %b/%h/%b exp 1/DEADBEEF/1001", Reg_We, Reg_Wdata, Flags); end
      tick();
      checks++; if ({Reg_We, Mem_Address} !== {1'b0, 16'h0016}) begin errors++; $display("FAIL ldr_next: got %b/%h exp 0/0016", Reg_We, Mem_Address); end
   endtask

   task automatic test_str();
      Mem_Rdata = 32'hEB800000;
      tick();
      Reg_Rdata1 = 32'd7; Reg_Rdata2 = 32'd99; Alu_Flags = 4'b0000;
      tick();
      checks++; if ({Mem_Enable, Mem_RW, Mem_Address, Mem_Wdata} !== {2'b10, 16'h0007, 32'd99}) begin errors++; $display("FAIL str_mem: got %b/%b/%h/%h exp 1/0/0007/63", Mem_Enable, Mem_RW, Mem_Address, Mem_Wdata); end
      checks++; if (Reg_We !== 1'b0) begin errors++; $display("FAIL str_no_we: got %b exp 0", Reg_We); end
      tick();
      checks++; if ({Reg_We, Mem_RW, Mem_Address, Flags} !== {2'b01, 16'h0017, 4'b1001}) begin errors++; $display("FAIL str_done: got %b/%b/%h/%b exp 0/1/0017/1001", Reg_We, Mem_RW, Mem_Address, Flags); end
   endtask

   task automatic test_halt_wrap();
      Mem_Rdata = 32'hEF000000;
      tick(); tick();
      checks++; if ({Halted, Busy, PC} !== {2'b10, 8'h18}) begin errors++; $display("FAIL halt_state: got %b/%b/%h exp 1/0/18", Halted, Busy, PC); end
      Mem_Ready = 1'b0;
      start_at(8'hFF);
      checks++; if ({Halted, Mem_Address} !== {1'b0, 16'h00FF}) begin errors++; $display("FAIL restart_ff: got %b/%h exp 0/00FF", Halted, Mem_Address); end
      Start_Addr = 8'h40; Start = 1'b1;
      tick();
      Start = 1'b0;
      checks++; if ({PC, Mem_Address} !== {8'hFF, 16'h00FF}) begin errors++; $display("FAIL start_busy_ignored: got %h/%h exp FF/00FF", PC, Mem_Address); end
      Mem_Ready = 1'b1;
      tick();
      checks++; if (PC !== 8'h00) begin errors++; $display("FAIL pc_wrap: got %h exp 00", PC); end
      tick();
      checks++; if ({Halted, Busy, PC} !== {2'b10, 8'h00}) begin errors++; $display("FAIL halt_wrap: got %b/%b/%h exp 1/0/00", Halted, Busy, PC); end
      start_at(8'h20);
      checks++; if ({Halted, Busy, Mem_Address} !== {2'b01, 16'h0020}) begin errors++; $display("FAIL restart_20: got %b/%b/%h exp 0/1/0020", Halted, Busy, Mem_Address); end
   endtask

   task automatic test_reset_mid_access();
      Mem_Rdata = 32'hEA000000; Mem_Ready = 1'b1;
      tick();
      Reg_Rdata1 = 32'h30; Mem_Ready = 1'b0;
      tick();
      checks++; if ({Mem_Enable, Mem_Address} !== {1'b1, 16'h0030}) begin errors++; $display("FAIL ldr2_wait: got %b/%h exp 1/0030", Mem_Enable, Mem_Address); end
      Reset = 1'b0;
      #1;
      checks++; if ({Mem_Enable, Busy, Reg_We, PC} !== 11'h000) begin errors++; $display("FAIL rst_async_ctl: got %b/%b/%b/%h exp 0/0/0/00", Mem_Enable, Busy, Reg_We, PC); end
      checks++; if ({Instruction, Reg_Wdata, Flags} !== 68'h0) begin errors++; $display("FAIL rst_async_data: got %h/%h/%b exp 0/0/0000", Instruction, Reg_Wdata, Flags); end
      Mem_Ready = 1'b1; Mem_Rdata = 32'h12345678;
      tick();
      checks++; if ({Reg_We, Reg_Wdata} !== 33'h0) begin errors++; $display("FAIL rst_no_wb: got %b/%h exp 0/0", Reg_We, Reg_Wdata); end
      Reset = 1'b1;
      tick();
      checks++; if ({Busy, Mem_Enable, Reg_We} !== 3'b000) begin errors++; $display("FAIL rst_release_idle: got %b exp 000", {Busy, Mem_Enable, Reg_We}); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_cond();
      test_ldr();
      test_str();
      test_halt_wrap();
      test_reset_mid_access();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
